id_ex_latch: RTL
================

// Module: id_ex_latch
// PURPOSE
//  Decode-to-execute pipeline register for the 5-stage MIPS datapath; captures register-file read data
//  (rdat1/rdat2) plus decoded control each advancing cycle and presents it to the EX stage.
//  Detects load-use hazards against the instruction in EX and inserts a one-cycle bubble.
//  Optionally bypasses the same-cycle writeback value around the register file (write-then-read hazard).
// PARAMETERS
//  WORD_W   32  datapath width (matches word_t)
//  RADDR_W  5   register index width (32 GPRs, $0 hardwired zero)
// PORTS
//  CLK          in   1        clock, rising edge
//  nRST         in   1        reset, asynchronous, active-low
//  en           in   1        pipeline advance (ihit & ~dstall from hazard/cache logic)
//  stall        in   1        external hold: latch keeps contents, lu_stall logic still evaluated
//  flush        in   1        squash: next latched entry is a bubble (branch/jump mispredict)
//  id_valid     in   1        ID stage holds a real instruction
//  id_pc        in   WORD_W   PC of ID instruction
//  id_instr     in   WORD_W   raw instruction word
//  id_rsel1     in   RADDR_W  rs index (also drives rfif.rsel1)
//  id_rsel2     in   RADDR_W  rt index (also drives rfif.rsel2)
//  id_wsel      in   RADDR_W  destination index
//  id_wen       in   1        instruction writes a GPR
//  id_memread   in   1        instruction is a load
//  rdat1/rdat2  in   WORD_W   register-file read data for rs/rt
//  wb_wen       in   1        writeback enable (same signal as rfif.WEN)
//  wb_wsel      in   RADDR_W  writeback index
//  wb_wdat      in   WORD_W   writeback data
//  ex_valid     out  1        EX entry is a real instruction
//  ex_pc, ex_instr  out WORD_W  latched PC / instruction
//  ex_rdat1, ex_rdat2 out WORD_W latched operands
//  ex_rs, ex_rt, ex_wsel out RADDR_W  latched indices
//  ex_wen, ex_memread out 1   latched control, forced 0 when ex_valid=0
//  lu_stall     out  1        combinational: hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset: every output register 0 (ex_valid=0, ex_wen=0, ex_memread=0, all data 0); lu_stall=0.
//  - lu_stall = ex_valid & ex_memread & ex_wen & (ex_wsel!=0) & id_valid &
//    ((ex_wsel==id_rsel1) | (ex_wsel==id_rsel2)).
//  - Per-edge update priority: flush > stall > lu_stall > en > hold.
//    flush: ex_valid<=0, ex_wen<=0, ex_memread<=0 (data fields don't-care, hold). Applies even if en=0.
//    stall (no flush): all fields hold.
//    lu_stall & en: insert bubble (as flush); ID instruction stays in IF/ID, re-presented next cycle.
//    en: capture all id_* fields; ex_valid<=id_valid; ex_wen/ex_memread <= id_* & id_valid.
//    none: hold.
//  - Latency: 1 cycle ID->EX. Load-use costs exactly one bubble: after bubble, ex_valid=0 so lu_stall
//    deasserts and the dependent instruction advances next en.
//  - Operands with index 0 latch 0 regardless of rdat/bypass.
//  - Async reset mid-stall/mid-bubble: everything cleared; no pending bubble state survives.
// CONFIGURATION
//  WB_BYPASS_EN defined: when capturing, if wb_wen & wb_wsel!=0 & wb_wsel==id_rselN, operand N
//    latches wb_wdat instead of rdatN (register file commits on the same edge, so rdat is stale).
//  WB_BYPASS_EN undefined: operands always latch rdat1/rdat2; writeback stage must split write/read
//    phases or insert stalls itself.
// TESTING
//  1 Reset: nRST=0 with random inputs -> all outputs 0; release, en=0 -> outputs stay 0.
//  2 Advance: id_pc=0x40, rdat1=0x11, rdat2=0x22, id_valid=1, en=1 -> next cycle ex_pc=0x40,
//    ex_rdat1=0x11, ex_rdat2=0x22, ex_valid=1.
//  3 Load-use: EX holds lw $5 (memread, wsel=5); ID add rs=5 -> lu_stall=1, next edge ex_valid=0;
//    following edge add captured, ex_rs=5, lu_stall=0.
//  4 Flush vs stall: flush=1, stall=1, en=1 with valid EX entry -> ex_valid=0, ex_wen=0 after edge.
//  5 Bypass (WB_BYPASS_EN): wb_wen=1, wb_wsel=7, wb_wdat=0xDEAD, id_rsel2=7, rdat2=0x1 -> ex_rdat2=0xDEAD;
//    without macro -> 0x1. wb_wsel=0 -> never bypassed.
//  6 $0 operand: id_rsel1=0, rdat1=0xFFFF -> ex_rdat1=0; lw $0 in EX never raises lu_stall.

Source files
------------

// File: rtl/id_ex_latch.sv
// -----------------------------------------------------------------------------
// id_ex_latch
//   Decode-to-execute pipeline register for the 5-stage MIPS datapath.
//   Captures register-file read data plus decoded control on each advancing
//   edge and presents it to EX. It detects load-use hazards against the
//   instruction currently in EX. When it finds one it inserts a one-cycle bubble.
//
//   Optional feature (macro WB_BYPASS_EN): when defined, the same-cycle
//   writeback value is forwarded around the register file into the latched
//   operands. The register file commits on the same edge, so rdat is stale then.
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   en                   pipeline advance
//   stall                external hold (lu_stall still evaluated)
//   flush                squash: next latched entry is a bubble
//   id_*                 ID-stage instruction fields
//   rdat1, rdat2         register-file read data for rs / rt
//   wb_wen/wsel/wdat     writeback port (used only for the bypass)
//   ex_*                 latched EX-stage entry
//   lu_stall             combinational load-use hazard: hold PC and IF/ID
// -----------------------------------------------------------------------------
module id_ex_latch #(
    parameter int WORD_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               en,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [WORD_W-1:0]  id_pc,
    input  logic [WORD_W-1:0]  id_instr,
    input  logic [RADDR_W-1:0] id_rsel1,
    input  logic [RADDR_W-1:0] id_rsel2,
    input  logic [RADDR_W-1:0] id_wsel,
    input  logic               id_wen,
    input  logic               id_memread,
    input  logic [WORD_W-1:0]  rdat1,
    input  logic [WORD_W-1:0]  rdat2,
    input  logic               wb_wen,
    input  logic [RADDR_W-1:0] wb_wsel,
    input  logic [WORD_W-1:0]  wb_wdat,
    output logic               ex_valid,
    output logic [WORD_W-1:0]  ex_pc,
    output logic [WORD_W-1:0]  ex_instr,
    output logic [WORD_W-1:0]  ex_rdat1,
    output logic [WORD_W-1:0]  ex_rdat2,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_wsel,
    output logic               ex_wen,
    output logic               ex_memread,
    output logic               lu_stall
);

    logic               valid_q,   valid_d;
    logic [WORD_W-1:0]  pc_q,      pc_d;
    logic [WORD_W-1:0]  instr_q,   instr_d;
    logic [WORD_W-1:0]  rdat1_q,   rdat1_d;
    logic [WORD_W-1:0]  rdat2_q,   rdat2_d;
    logic [RADDR_W-1:0] rs_q,      rs_d;
    logic [RADDR_W-1:0] rt_q,      rt_d;
    logic [RADDR_W-1:0] wsel_q,    wsel_d;
    logic               wen_q,     wen_d;
    logic               memread_q, memread_d;

    logic [WORD_W-1:0]  op1, op2;

    // Hazard against the load sitting in EX. A load to $0 never produces a
    // value, so it cannot cause a hazard.
    always_comb begin
        lu_stall = valid_q & memread_q & wen_q & (wsel_q != '0) & id_valid &
                   ((wsel_q == id_rsel1) | (wsel_q == id_rsel2));
    end

    // Operand selection: $0 always reads as zero. The bypass takes priority
    // over the stale register-file read.
    always_comb begin
        op1 = rdat1;
        op2 = rdat2;
`ifdef WB_BYPASS_EN
        if (wb_wen && (wb_wsel != '0) && (wb_wsel == id_rsel1)) op1 = wb_wdat;
        if (wb_wen && (wb_wsel != '0) && (wb_wsel == id_rsel2)) op2 = wb_wdat;
`endif
        if (id_rsel1 == '0) op1 = '0;
        if (id_rsel2 == '0) op2 = '0;
    end

    // Priority: flush > stall > load-use bubble > advance > hold.
    // Bubbles clear only valid/control bits; data fields keep their values.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        rdat1_d   = rdat1_q;
        rdat2_d   = rdat2_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        wsel_d    = wsel_q;
        wen_d     = wen_q;
        memread_d = memread_q;
        if (flush || (!stall && lu_stall && en)) begin
            valid_d   = 1'b0;
            wen_d     = 1'b0;
            memread_d = 1'b0;
        end else if (!stall && en) begin
            valid_d   = id_valid;
            pc_d      = id_pc;
            instr_d   = id_instr;
            rdat1_d   = op1;
            rdat2_d   = op2;
            rs_d      = id_rsel1;
            rt_d      = id_rsel2;
            wsel_d    = id_wsel;
            wen_d     = id_wen & id_valid;
            memread_d = id_memread & id_valid;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            rdat1_q   <= '0;
            rdat2_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            wsel_q    <= '0;
            wen_q     <= 1'b0;
            memread_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            rdat1_q   <= rdat1_d;
            rdat2_q   <= rdat2_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            wsel_q    <= wsel_d;
            wen_q     <= wen_d;
            memread_q <= memread_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_instr   = instr_q;
    assign ex_rdat1   = rdat1_q;
    assign ex_rdat2   = rdat2_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_wsel    = wsel_q;
    assign ex_wen     = wen_q;
    assign ex_memread = memread_q;

endmodule
